// File: rtl/icap_cmd_seq_pkg.sv
// icap_cmd_seq_pkg: states, ICAP command words and the type-1 packet header builder.
package icap_cmd_seq_pkg;
    typedef enum logic [3:0] {
        IDLE, PRE, HDR, WDATA, PAD, RD_TURN, RD_WAIT, RD_BACK, DESYNC, TAIL, DONE
    } state_t;
    localparam logic [15:0] DUMMY      = 16'hFFFF;
    localparam logic [15:0] SYNC0      = 16'hAA99;
    localparam logic [15:0] SYNC1      = 16'h5566;
    localparam logic [15:0] NOOP       = 16'h2000;
    localparam logic [15:0] DESYNC_CMD = 16'h000D;
    localparam logic [1:0]  OP_RD      = 2'b01;
    localparam logic [1:0]  OP_WR      = 2'b10;
    localparam logic [5:0]  CMD_ADDR   = 6'h05;
    function automatic logic [15:0] pkt_hdr(input logic [1:0] op, input logic [5:0] addr);
        return {3'b001, op, addr, 5'd1};
    endfunction
endpackage

// File: rtl/icap_bitswap16.sv
// icap_bitswap16: reverses the bit order inside each byte of a 16-bit word.
module icap_bitswap16 (
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);
    for (genvar b = 0; b < 8; b++) begin : g_bit
        assign o_q[b]     = i_d[7-b];
        assign o_q[8+b]   = i_d[15-b];
    end
endmodule

// File: rtl/icap_cmd_seq.sv
// icap_cmd_seq: issues ICAP sync/header/data/desync sequences for single config register reads and writes.
// Define ICAP_CMD_SEQ_BITSWAP_EN to bit-reverse each byte of the ICAP I and O buses.
module icap_cmd_seq
    import icap_cmd_seq_pkg::*;
#(
    parameter int NOOP_PAD   = 2,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [5:0]  i_req_addr,
    input  logic [15:0] i_req_data,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_icap_ce_n,
    output logic        o_icap_write_n,
    output logic [15:0] o_icap_i,
    input  logic [15:0] i_icap_o,
    input  logic        i_icap_busy
);
    localparam logic [15:0] PAD_LAST = 16'(NOOP_PAD - 1);
    localparam logic [15:0] TO_LAST  = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] TO_MAX   = 16'(RD_TIMEOUT);

    state_t      r_state, w_nxt;
    logic [15:0] r_cnt, r_data, r_rsp_data, w_word, w_tx, w_rx;
    logic [5:0]  r_addr;
    logic        r_write, r_rsp_err, w_ce_n, w_wr_n, w_stall, w_timeout;

`ifdef ICAP_CMD_SEQ_BITSWAP_EN
    icap_bitswap16 u_swap_i (.i_d(w_word),   .o_q(w_tx));
    icap_bitswap16 u_swap_o (.i_d(i_icap_o), .o_q(w_rx));
`else
    assign w_tx = w_word;
    assign w_rx = i_icap_o;
`endif

    // A busy ICAP during any written word freezes the word and the counter.
    assign w_stall   = !w_ce_n && !w_wr_n && i_icap_busy;
    assign w_timeout = i_icap_busy && r_cnt >= TO_LAST;

    always_comb begin
        w_nxt  = r_state;
        w_ce_n = 1'b0;
        w_wr_n = 1'b0;
        w_word = DUMMY;
        case (r_state)
            IDLE: begin
                w_ce_n = 1'b1;
                if (i_req_valid) w_nxt = PRE;
            end
            PRE: begin
                w_word = r_cnt == 16'd0 ? DUMMY : r_cnt == 16'd1 ? SYNC0 : r_cnt == 16'd2 ? SYNC1 : NOOP;
                if (!i_icap_busy && r_cnt == 16'd3) w_nxt = HDR;
            end
            HDR: begin
                w_word = pkt_hdr(r_write ? OP_WR : OP_RD, r_addr);
                if (!i_icap_busy) w_nxt = r_write ? WDATA : PAD;
            end
            WDATA: begin
                w_word = r_data;
                if (!i_icap_busy) w_nxt = PAD;
            end
            PAD: begin
                w_word = NOOP;
                if (!i_icap_busy && r_cnt == PAD_LAST) w_nxt = r_write ? DESYNC : RD_TURN;
            end
            RD_TURN: begin
                w_ce_n = 1'b1;
                w_wr_n = r_cnt[0];
                if (r_cnt[0]) w_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                w_wr_n = 1'b1;
                if (!i_icap_busy || r_cnt >= TO_LAST) w_nxt = RD_BACK;
            end
            RD_BACK: begin
                w_ce_n = 1'b1;
                w_wr_n = !r_cnt[0];
                if (r_cnt[0]) w_nxt = DESYNC;
            end
            DESYNC: begin
                w_word = r_cnt[0] ? DESYNC_CMD : pkt_hdr(OP_WR, CMD_ADDR);
                if (!i_icap_busy && r_cnt[0]) w_nxt = TAIL;
            end
            TAIL: begin
                w_word = NOOP;
                if (!i_icap_busy && r_cnt == PAD_LAST) w_nxt = DONE;
            end
            default: begin
                w_ce_n = 1'b1;
                w_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (w_nxt != r_state) ? '0 :
                       (w_stall || (r_state == RD_WAIT && r_cnt == TO_MAX)) ? r_cnt : r_cnt + 16'd1;
            if (r_state == IDLE && i_req_valid) begin
                r_write    <= i_req_write;
                r_addr     <= i_req_addr;
                r_data     <= i_req_data;
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b0;
            end
            if (r_state == RD_WAIT && !i_icap_busy) begin
                r_rsp_data <= w_rx;
            end else if (r_state == RD_WAIT && w_timeout) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign o_req_ready    = r_state == IDLE;
    assign o_rsp_valid    = r_state == DONE;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_err      = r_rsp_err;
    assign o_icap_ce_n    = w_ce_n;
    assign o_icap_write_n = w_wr_n;
    assign o_icap_i       = w_tx;
endmodule

// File: tb/tb_icap_cmd_seq.sv
// tb_icap_cmd_seq: random and directed register reads/writes checked against a word-list model of the ICAP protocol.
module tb_icap_cmd_seq;
    localparam int PAD = 2;
    localparam int TMO = 8;

    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_req_valid = 1'b0, i_req_write = 1'b0, i_icap_busy = 1'b0;
    logic [5:0]  i_req_addr = '0;
    logic [15:0] i_req_data = '0, i_icap_o = '0;
    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_icap_ce_n, o_icap_write_n;
    logic [15:0] o_rsp_data, o_icap_i;

    int          n_vec = 0, n_err = 0;
    logic [15:0] exp_q[$];

    icap_cmd_seq #(.NOOP_PAD(PAD), .RD_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_icap_ce_n(o_icap_ce_n), .o_icap_write_n(o_icap_write_n), .o_icap_i(o_icap_i),
        .i_icap_o(i_icap_o), .i_icap_busy(i_icap_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Logical word <-> pin word; the mapping is its own inverse.
    function automatic logic [15:0] bus(input logic [15:0] w);
        logic [15:0] r;
        r = w;
`ifdef ICAP_CMD_SEQ_BITSWAP_EN
        for (int k = 0; k < 8; k++) begin
            r[k]   = w[7-k];
            r[8+k] = w[15-k];
        end
`endif
        return r;
    endfunction

    function automatic logic [15:0] hdr(input bit wr, input logic [5:0] a);
        return {3'b001, wr ? 2'b10 : 2'b01, a, 5'd1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_pre(input bit wr, input logic [5:0] a);
        exp_q = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000};
        exp_q.push_back(hdr(wr, a));
    endtask

    task automatic push_pad();
        for (int k = 0; k < PAD; k++) exp_q.push_back(16'h2000);
    endtask

    task automatic push_tail();
        exp_q.push_back(16'h30A1);
        exp_q.push_back(16'h000D);
        push_pad();
    endtask

    // Plays out exp_q: every written cycle shows the head word; busy cycles keep it.
    task automatic drain(input int bpct, input int hold_idx, input int hold_len,
                         input logic [15:0] watch, output int nwatch);
        int popped = 0, held = 0, guard = 0;
        nwatch = 0;
        while (exp_q.size() > 0) begin
            if (popped == hold_idx && held < hold_len) begin
                i_icap_busy = 1'b1;
                held++;
            end else begin
                i_icap_busy = $urandom_range(99) < bpct;
            end
            i_req_valid = 1'($urandom_range(1));
            @(negedge i_clk);
            chk("wr_ce_n", o_icap_ce_n, 0);
            chk("wr_write_n", o_icap_write_n, 0);
            chk("wr_word", o_icap_i, bus(exp_q[0]));
            chk("busy_ready", o_req_ready, 0);
            if (o_icap_i == bus(watch)) nwatch++;
            if (!i_icap_busy) begin
                void'(exp_q.pop_front());
                popped++;
            end
            @(posedge i_clk); #1;
            guard++;
            if (guard > 400) begin
                chk("drain_timeout", 1, 0);
                exp_q.delete();
            end
        end
        i_icap_busy = 1'b0;
        i_req_valid = 1'b0;
    endtask

    task automatic start_req(input bit wr, input logic [5:0] a, input logic [15:0] d);
        int g = 0;
        while (!o_req_ready && g < 50) begin
            @(posedge i_clk); #1;
            g++;
        end
        chk("req_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = a;
        i_req_data  = d;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_req_write = 1'($urandom);
        i_req_addr  = 6'($urandom);
        i_req_data  = 16'($urandom);
    endtask

    task automatic finish_op(input logic [15:0] d, input bit e);
        @(negedge i_clk);
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_data", o_rsp_data, d);
        chk("rsp_err", o_rsp_err, e);
        chk("done_ce_n", o_icap_ce_n, 1);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("idle_valid", o_rsp_valid, 0);
        chk("idle_ready", o_req_ready, 1);
        chk("idle_ce_n", o_icap_ce_n, 1);
        chk("idle_write_n", o_icap_write_n, 0);
        chk("idle_i", o_icap_i, 16'hFFFF);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d, input int bpct,
                            input int hold_idx, input int hold_len, output int nwatch);
        start_req(1'b1, a, d);
        push_pre(1'b1, a);
        exp_q.push_back(d);
        push_pad();
        push_tail();
        drain(bpct, hold_idx, hold_len, d, nwatch);
        finish_op(16'h0000, 1'b0);
    endtask

    // lat = busy cycles seen in RD_WAIT before it drops; lat >= TMO never drops in time.
    task automatic do_read(input logic [5:0] a, input int bpct, input int lat, input logic [15:0] raw);
        int nw, nwait;
        start_req(1'b0, a, 16'($urandom));
        push_pre(1'b0, a);
        push_pad();
        drain(bpct, -1, 0, 16'h0000, nw);
        i_icap_busy = 1'($urandom);
        @(negedge i_clk);
        chk("turn0_ce_n", o_icap_ce_n, 1);
        chk("turn0_write_n", o_icap_write_n, 0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("turn1_ce_n", o_icap_ce_n, 1);
        chk("turn1_write_n", o_icap_write_n, 1);
        @(posedge i_clk); #1;
        nwait = lat >= TMO ? TMO : lat + 1;
        for (int k = 0; k < nwait; k++) begin
            i_icap_busy = k < lat;
            i_icap_o    = k < lat ? 16'($urandom) : raw;
            @(negedge i_clk);
            chk("wait_ce_n", o_icap_ce_n, 0);
            chk("wait_write_n", o_icap_write_n, 1);
            @(posedge i_clk); #1;
        end
        i_icap_busy = 1'($urandom);
        i_icap_o    = 16'($urandom);
        @(negedge i_clk);
        chk("back0_ce_n", o_icap_ce_n, 1);
        chk("back0_write_n", o_icap_write_n, 1);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("back1_ce_n", o_icap_ce_n, 1);
        chk("back1_write_n", o_icap_write_n, 0);
        @(posedge i_clk); #1;
        push_tail();
        exp_q = exp_q[exp_q.size()-(PAD+2):$];
        drain(bpct, -1, 0, 16'h0000, nw);
        finish_op(lat >= TMO ? 16'h0000 : bus(raw), lat >= TMO);
    endtask

    initial begin
        int nw;
        #12;
        chk("rst_ready", o_req_ready, 1);
        chk("rst_valid", o_rsp_valid, 0);
        chk("rst_data", o_rsp_data, 0);
        chk("rst_err", o_rsp_err, 0);
        chk("rst_ce_n", o_icap_ce_n, 1);
        chk("rst_write_n", o_icap_write_n, 0);
        chk("rst_i", o_icap_i, 16'hFFFF);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        do_write(6'h0A, 16'h1234, 0, -1, 0, nw);
        do_write(6'h0A, 16'h1234, 0, 5, 2, nw);
        chk("wdata_hold", nw, 3);
        do_read(6'h0A, 0, 3, bus(16'hBEEF));
        do_read(6'h0A, 0, 100, 16'h1357);
        do_read(6'h13, 0, 0, 16'h0180);
        do_read(6'h21, 0, TMO - 1, 16'hC3A5);

        start_req(1'b1, 6'h0A, 16'h1234);
        exp_q = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000};
        drain(0, -1, 0, 16'h0000, nw);
        @(negedge i_clk);
        chk("abort_hdr", o_icap_i, bus(16'h3141));
        #2 i_rst = 1'b1;
        #1;
        chk("abort_ce_n", o_icap_ce_n, 1);
        chk("abort_ready", o_req_ready, 1);
        chk("abort_valid", o_rsp_valid, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("abort_no_rsp", o_rsp_valid, 0);
        end
        do_write(6'h0A, 16'h1234, 0, -1, 0, nw);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(1))
                do_write(6'($urandom), 16'($urandom), $urandom_range(40), -1, 0, nw);
            else
                do_read(6'($urandom), $urandom_range(40), $urandom_range(TMO + 2), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/icap_cmd_seq.md
ICAP_CMD_SEQ -- requirements
Module: icap_cmd_seq

Interface
REQ-001 Parameter NOOP_PAD, default 2: number of NOOP words (0x2000) issued after each header and after the desync data word; legal range 1..15.
REQ-002 Parameter RD_TIMEOUT, default 255: maximum CLK cycles to wait for icap_busy low during a read; legal range 1..65535.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST  in  1  asynchronous reset, active-high.
REQ-005 req_valid  in  1  request strobe; req_ready  out  1  sequencer idle and able to accept.
REQ-006 req_write  in  1  1 = register write, 0 = register read; req_addr  in  6  config register address; req_data  in  16  write data.
REQ-007 rsp_valid  out  1  one-cycle completion pulse; rsp_data  out  16  read data (0 for writes); rsp_err  out  1  read timeout flag, qualified by rsp_valid.
REQ-008 icap_ce_n  out  1  ICAP CE, active-low; icap_write_n  out  1  ICAP WRITE (0 = write, 1 = read); icap_i  out  16  ICAP I bus.
REQ-009 icap_o  in  16  ICAP O bus; icap_busy  in  1  ICAP BUSY.

Function
REQ-010 Handshake: a request is accepted on a cycle where req_valid=1 and req_ready=1; the request fields are captured on that edge and req_ready deasserts on the following cycle.
REQ-011 Packet header word: {3'b001, op[1:0], addr[5:0], 5'd1}, where op=2'b10 for a write and 2'b01 for a read.
REQ-012 Write sequence, one word per cycle with icap_ce_n=0 and icap_write_n=0: 0xFFFF, 0xAA99, 0x5566, NOOP, write header, req_data, NOOP_PAD NOOPs, 0x30A1, 0x000D, then NOOP_PAD NOOPs.
REQ-013 Read sequence: 0xFFFF, 0xAA99, 0x5566, NOOP, read header, NOOP_PAD NOOPs.
REQ-014 Read turnaround: after the read sequence, drive icap_ce_n=1 for 1 cycle, then icap_write_n=1 for 1 cycle, then icap_ce_n=0 (state RD_WAIT).
REQ-015 In RD_WAIT, on the first cycle with icap_busy=0, capture icap_o into rsp_data.
REQ-016 After the capture, drive icap_ce_n=1 for 1 cycle and icap_write_n=0 for 1 cycle, then emit the desync tail from REQ-012: 0x30A1, 0x000D, NOOP_PAD NOOPs.
REQ-017 Any issued word that coincides with icap_busy=1 in a write phase shall be held and reissued; the sequence does not advance.
REQ-018 State machine: IDLE, PRE (dummy/sync/NOOP), HDR, WDATA, PAD, RD_TURN, RD_WAIT, RD_BACK, DESYNC, TAIL, DONE.
REQ-019 DONE lasts one cycle, asserts rsp_valid, then returns to IDLE.
REQ-020 Timeout: if icap_busy stays 1 for RD_TIMEOUT cycles in RD_WAIT, set rsp_data=0 and rsp_err=1, then take the RD_BACK and desync path.
REQ-021 When idle: icap_ce_n=1, icap_write_n=0, icap_i=0xFFFF.
REQ-022 req_valid asserted during an operation is ignored; it is not queued.
REQ-023 The cycle counter saturates at RD_TIMEOUT; it shall not wrap.

Reset
REQ-024 RST asynchronously forces IDLE, including when asserted mid-operation. Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, icap_ce_n=1, icap_write_n=0, icap_i=0xFFFF. No response is issued for an aborted operation.

Configuration
REQ-025 Macro ICAP_CMD_SEQ_BITSWAP_EN, when defined: bit-reverse each byte of icap_i on output and each byte of icap_o on capture. Example: logical 0xAA99 is driven as 0x5599.
REQ-026 When ICAP_CMD_SEQ_BITSWAP_EN is undefined: icap_i and icap_o pass unmodified.

Structure
REQ-027 Package icap_cmd_seq_pkg holds the state enum and the constants DUMMY=0xFFFF, SYNC0=0xAA99, SYNC1=0x5566, NOOP=0x2000, OP_RD, OP_WR, CMD_ADDR=6'h05 and DESYNC_CMD=0x000D.
REQ-028 Sub-module icap_bitswap16, a combinational per-byte bit reversal, is instantiated twice (I and O paths) only under ICAP_CMD_SEQ_BITSWAP_EN.

Verification
REQ-029 Write addr 0x0A, data 0x1234, NOOP_PAD=2 -> icap_i sequence FFFF, AA99, 5566, 2000, 3141, 1234, 2000, 2000, 30A1, 000D, 2000, 2000; then rsp_valid=1, rsp_err=0.
REQ-030 Read addr 0x0A; icap_busy low 3 cycles after RD_WAIT entry with icap_o=0xBEEF -> header 0x2941, rsp_data=0xBEEF, rsp_err=0, desync tail emitted.
REQ-031 Read with icap_busy held at 1, RD_TIMEOUT=8 -> rsp_valid after exactly 8 RD_WAIT cycles, rsp_err=1, rsp_data=0.
REQ-032 Assert RST during HDR of a write -> same cycle icap_ce_n=1, req_ready=1; no rsp_valid; the next request runs a full sequence.
REQ-033 icap_busy=1 for 2 cycles during WDATA -> 0x1234 held for 3 cycles, total sequence length +2.
REQ-034 With ICAP_CMD_SEQ_BITSWAP_EN defined -> the SYNC0 word appears as 0x5599 and a read of icap_o=0x0180 returns 0x8001.
